// File: rtl/noc_link_out_arbiter.sv
// Packet-atomic round-robin arbiter sharing one tile->NoC output link between
// several flit sources, with a single registered output stage.
module noc_link_out_arbiter #(
  parameter int unsigned FLIT_WIDTH = 34,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [CHANNELS-1:0][FLIT_WIDTH-1:0]  req_flit,
  input  logic [CHANNELS-1:0]                  req_last,
  input  logic [CHANNELS-1:0]                  req_valid,
  output logic [CHANNELS-1:0]                  req_ready,
  output logic [FLIT_WIDTH-1:0]                link_out_flit,
  output logic                                 link_out_last,
  output logic                                 link_out_valid,
  input  logic                                 link_out_ready,
  output logic [CW-1:0]                        link_out_chan,
  output logic                                 busy
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               state;
  logic [CW-1:0]        owner;
  logic [CW-1:0]        rr_ptr;

  logic                 space;
  logic                 any_valid;
  logic [CW-1:0]        sel;
  logic [CW-1:0]        grant;
  logic [CW-1:0]        next_ptr;
  logic [CHANNELS-1:0]  ready_c;
  logic                 xfer;

  // Cyclic search for the first valid requester starting at rr_ptr.
  always_comb begin
    logic [CW-1:0] idx;
    sel       = rr_ptr;
    any_valid = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      idx = CW'((32'(rr_ptr) + k) % CHANNELS);
      if (!any_valid && req_valid[idx]) begin
        sel       = idx;
        any_valid = 1'b1;
      end
    end
  end

  assign space    = !link_out_valid || link_out_ready;
  assign grant    = (state == LOCKED) ? owner : sel;
  assign next_ptr = CW'((32'(grant) + 1) % CHANNELS);

  // Only the granted requester may see ready; never during reset.
  always_comb begin
    ready_c = '0;
    if (rst && space && ((state == LOCKED) || any_valid))
      ready_c[grant] = 1'b1;
  end

  assign req_ready = ready_c;
  assign xfer      = req_valid[grant] && ready_c[grant];
  assign busy      = (state == LOCKED) || link_out_valid;

  // Arbitration state and output stage share one register process.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      owner          <= '0;
      rr_ptr         <= '0;
      link_out_valid <= 1'b0;
      link_out_flit  <= '0;
      link_out_last  <= 1'b0;
      link_out_chan  <= '0;
    end else begin
      if (xfer) begin
        link_out_flit  <= req_flit[grant];
        link_out_last  <= req_last[grant];
        link_out_chan  <= grant;
        link_out_valid <= 1'b1;
        if (req_last[grant]) begin
          state  <= IDLE;
          rr_ptr <= next_ptr;
        end else begin
          state  <= LOCKED;
          owner  <= grant;
        end
      end else if (link_out_ready) begin
        link_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/noc_link_out_arbiter.md
Name: noc_link_out_arbiter

Overview:
- Shares one tile->NoC physical output link between CHANNELS requesters (per-channel flit sources inside the tile), e.g. DMA and message-passing endpoints.
- Packet-atomic round-robin arbitration: once a requester is granted, it owns the link until its flit with last=1 is accepted.
- A single registered output stage drives link_out_flit/last/valid toward the NoC router.

Parameters:
- FLIT_WIDTH, 34, width of one flit.
- CHANNELS, 2, number of requesters; must be >= 1.
- CW, (CHANNELS>1 ? $clog2(CHANNELS) : 1), width of the channel index.

Ports:
- clk  input  1  clock, all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_flit  input  CHANNELS x FLIT_WIDTH  flit offered by each requester.
- req_last  input  CHANNELS  final flit of a packet, per requester.
- req_valid  input  CHANNELS  flit valid, per requester.
- req_ready  output  CHANNELS  flit accepted this cycle, per requester.
- link_out_flit  output  FLIT_WIDTH  registered flit to the NoC.
- link_out_last  output  1  registered last flag.
- link_out_valid  output  1  output stage holds a flit.
- link_out_ready  input  1  NoC accepts the flit.
- link_out_chan  output  CW  index of the requester that produced the current output flit.
- busy  output  1  high when state is LOCKED or link_out_valid=1.

Behaviour:
- Reset (rst=0, asynchronous):
  - link_out_valid=0, link_out_flit=0, link_out_last=0, link_out_chan=0.
  - state=IDLE, owner=0, rr_ptr=0.
  - req_ready forced to all 0 while rst=0.
- Transfer definitions:
  - accept_out = link_out_valid & link_out_ready.
  - space = !link_out_valid | link_out_ready. The output stage can load a flit in any cycle its current flit leaves.
  - Requester i transfers when req_valid[i] & req_ready[i].
- State IDLE:
  - sel = first index j with req_valid[j]=1, searching cyclically from rr_ptr. The search is combinational.
  - If any req_valid and space=1: req_ready[sel]=1 and all other req_ready bits are 0. The flit transfers this cycle.
  - If the transferred flit has last=0: state goes to LOCKED and owner=sel.
  - If the transferred flit has last=1 (single-flit packet): state stays IDLE and rr_ptr=(sel+1) mod CHANNELS.
  - If no req_valid, or space=0: req_ready=0 and no state change. Arbitration is re-evaluated every cycle until a transfer occurs.
- State LOCKED:
  - req_ready[owner]=space and all other req_ready bits are 0.
  - On a transfer with last=1: state goes to IDLE and rr_ptr=(owner+1) mod CHANNELS.
  - If the owner deasserts req_valid mid-packet, the lock is held indefinitely. There is no timeout and no interleaving of another requester.
- Output stage:
  - On a transfer: link_out_flit, link_out_last and link_out_chan load from the granted requester, and link_out_valid=1 on the next cycle.
  - On accept_out with no new transfer: link_out_valid=0 on the next cycle.
  - While link_out_valid=1 and link_out_ready=0, all link_out_* signals and link_out_chan are held stable.
  - Simultaneous accept_out and transfer: the new flit replaces the old one, link_out_valid stays 1, and there is no bubble.
- Timing:
  - Latency is 1 cycle from req transfer to link_out_valid.
  - Sustained throughput is 1 flit/cycle when link_out_ready is held 1.
  - A new packet from a different requester can start in the cycle directly after a last-flit transfer, with no idle cycle.
- Fairness: rr_ptr advances only on packet completion. With all requesters continuously valid, packets are served in order 0,1,...,CHANNELS-1,0.
- CHANNELS=1: always grants requester 0 and rr_ptr stays 0. Behaviour is otherwise identical.
- req_ready does not depend combinationally on req_last. It may depend on req_valid (IDLE selection) and on link_out_ready.
- Reset mid-packet: the lock and the output flit are discarded. Requesters must restart their packets after reset.

Test Plan:
1. Reset, then req_valid=2'b01 with a 3-flit packet 0xA,0xB,0xC (last on 0xC), link_out_ready=1 -> req_ready[0]=1 on 3 consecutive cycles; link_out_flit=0xA,0xB,0xC on the next 3 cycles with link_out_last=1 only on 0xC; link_out_chan=0; busy falls one cycle after 0xC leaves.
2. Both requesters valid from reset, each sending 2-flit packets, link_out_ready=1 -> output order is ch0,ch0,ch1,ch1,ch0,ch0; there are no interleaved flits and no idle cycles between packets.
3. During a ch0 packet, link_out_ready=0 for 4 cycles -> link_out_* are held constant, req_ready=0 for those cycles, and no flit is lost or duplicated when ready returns.
4. ch0 drops req_valid for 5 cycles mid-packet while ch1 is valid -> req_ready[1] stays 0 throughout; the lock is held and ch0's remaining flits follow when it revalidates.
5. Single-flit packets (last=1) alternating from ch0/ch1 with both valid -> grants alternate each cycle, rr_ptr toggles, and throughput is 1 flit/cycle.
6. rst asserted mid-packet with link_out_valid=1 -> link_out_valid=0 and req_ready=0 immediately (asynchronous); after release, ch1 valid alone -> granted, proving the lock was cleared.
